// File: rtl/dest_reg_pipe_if.sv
// Bundle of decode-side inputs and pipeline/hazard outputs for dest_reg_pipe.
// The master drives instruction fields and pipeline controls; the slave is the pipe itself.
interface dest_reg_pipe_if #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned STAGE_W    = 2
);
    logic                        in_valid;
    logic [REG_ADDR_W-1:0]       regB;
    logic [REG_ADDR_W-1:0]       destReg;
    logic [1:0]                  write_sel;
    logic                        stall;
    logic                        flush;
    logic [REG_ADDR_W-1:0]       src_a;
    logic [REG_ADDR_W-1:0]       src_b;

    logic [REG_ADDR_W-1:0]       write_reg;
    logic                        write_en;
    logic [DEPTH*REG_ADDR_W-1:0] stage_dest;
    logic [DEPTH-1:0]            stage_wen;
    logic                        hazard_a;
    logic [STAGE_W-1:0]          hazard_a_stage;
    logic                        hazard_b;
    logic [STAGE_W-1:0]          hazard_b_stage;

    modport master (
        output in_valid, regB, destReg, write_sel, stall, flush, src_a, src_b,
        input  write_reg, write_en, stage_dest, stage_wen,
        input  hazard_a, hazard_a_stage, hazard_b, hazard_b_stage
    );

    modport slave (
        input  in_valid, regB, destReg, write_sel, stall, flush, src_a, src_b,
        output write_reg, write_en, stage_dest, stage_wen,
        output hazard_a, hazard_a_stage, hazard_b, hazard_b_stage
    );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register select carried through DEPTH stages with stall/flush, plus
// combinational youngest-match hazard lookup for two source registers.
module dest_reg_pipe #(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned DEPTH       = 3,
    parameter bit          ZERO_REG_RO = 1'b1,
    parameter int unsigned STAGE_W     = 2
) (
    input logic            clk,
    input logic            reset,
    dest_reg_pipe_if.slave bus
);
    typedef logic [REG_ADDR_W-1:0] addr_t;

    addr_t            dest_q [DEPTH];
    addr_t            dest_d [DEPTH];
    logic [DEPTH-1:0] wen_q;
    logic [DEPTH-1:0] wen_d;

    logic  new_wen;
    addr_t new_dest;

    // Non-writing entries always carry dest 0 so stage_dest never shows stale indices.
    always_comb begin
        new_wen  = bus.in_valid & ~bus.write_sel[1];
        new_dest = bus.write_sel[0] ? bus.destReg : bus.regB;
        if (ZERO_REG_RO && (new_dest == '0)) begin
            new_wen = 1'b0;
        end
        if (!new_wen) begin
            new_dest = '0;
        end
    end

    // Flush advances the older stages even while stalled; only stage 0 gets a bubble.
    always_comb begin
        dest_d = dest_q;
        wen_d  = wen_q;
        if (bus.flush || !bus.stall) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                dest_d[i] = dest_q[i-1];
                wen_d[i]  = wen_q[i-1];
            end
            dest_d[0] = bus.flush ? '0 : new_dest;
            wen_d[0]  = bus.flush ? 1'b0 : new_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= '0;
            end
            wen_q <= '0;
        end else begin
            dest_q <= dest_d;
            wen_q  <= wen_d;
        end
    end

    always_comb begin
        bus.stage_dest = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.stage_dest[i*REG_ADDR_W +: REG_ADDR_W] = dest_q[i];
        end
    end

    assign bus.stage_wen = wen_q;
    assign bus.write_reg = dest_q[DEPTH-1];
    assign bus.write_en  = wen_q[DEPTH-1];

    // Scan oldest to youngest so the last hit written is the youngest matching stage.
    always_comb begin
        bus.hazard_a       = 1'b0;
        bus.hazard_a_stage = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (wen_q[i] && (dest_q[i] == bus.src_a)) begin
                bus.hazard_a       = 1'b1;
                bus.hazard_a_stage = STAGE_W'(i);
            end
        end
        if (ZERO_REG_RO && (bus.src_a == '0)) begin
            bus.hazard_a       = 1'b0;
            bus.hazard_a_stage = '0;
        end
    end

    always_comb begin
        bus.hazard_b       = 1'b0;
        bus.hazard_b_stage = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (wen_q[i] && (dest_q[i] == bus.src_b)) begin
                bus.hazard_b       = 1'b1;
                bus.hazard_b_stage = STAGE_W'(i);
            end
        end
        if (ZERO_REG_RO && (bus.src_b == '0)) begin
            bus.hazard_b       = 1'b0;
            bus.hazard_b_stage = '0;
        end
    end
endmodule

// File: tb/tb_dest_reg_pipe.sv
// Bench for dest_reg_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_dest_reg_pipe;
    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned DEPTH       = 3;
    localparam int unsigned STAGE_W     = 2;
    localparam bit          ZERO_REG_RO = 1'b1;

    typedef logic [REG_ADDR_W-1:0] addr_t;
    typedef struct {
        bit    wen;
        addr_t dest;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    entry_t pipe[$];

    always #5 clk = ~clk;

    dest_reg_pipe_if #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .STAGE_W(STAGE_W)) bus ();

    dest_reg_pipe #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .ZERO_REG_RO(ZERO_REG_RO),
        .STAGE_W    (STAGE_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Model: pipeline as a queue, index 0 = youngest stage.
    task automatic tick();
        entry_t e;
        entry_t bubble;
        bit rst, fl, st;
        bubble.wen  = 1'b0;
        bubble.dest = '0;
        e.wen  = bus.in_valid && (bus.write_sel < 2);
        e.dest = !e.wen ? '0 : ((bus.write_sel == 0) ? bus.regB : bus.destReg);
        if (ZERO_REG_RO && e.dest == 0) e.wen = 1'b0;
        if (!e.wen) e.dest = '0;
        rst = reset;
        fl  = bus.flush;
        st  = bus.stall;
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            repeat (DEPTH) pipe.push_back(bubble);
        end else if (fl) begin
            pipe.push_front(bubble);
            void'(pipe.pop_back());
        end else if (!st) begin
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    task automatic set_idle();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.write_sel = 2'd2;
        bus.regB      = '0;
        bus.destReg   = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
    endtask

    task automatic push(input addr_t d);
        bus.in_valid  = 1'b1;
        bus.write_sel = 2'd1;
        bus.destReg   = d;
        tick();
        bus.in_valid  = 1'b0;
        bus.write_sel = 2'd2;
    endtask

    function automatic void model_hazard(input addr_t src, output bit hit,
                                         output logic [STAGE_W-1:0] stg);
        hit = 1'b0;
        stg = '0;
        if (!(ZERO_REG_RO && src == 0)) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!hit && pipe[i].wen && pipe[i].dest == src) begin
                    hit = 1'b1;
                    stg = STAGE_W'(i);
                end
            end
        end
    endfunction

    task automatic test_reset();
        set_idle();
        reset     = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        set_idle();
        checks++;
        if (bus.stage_wen !== 3'b000 || bus.stage_dest !== '0) begin
            failures++;
            $display("FAIL reset_init: wen=%b dest=%h required wen=000 dest=0",
                     bus.stage_wen, bus.stage_dest);
        end
        push(3'd1); push(3'd2); push(3'd3);
        bus.src_a = 3'd1;
        #1;
        checks++;
        if (bus.hazard_a !== 1'b1 || bus.hazard_a_stage !== 2'd2) begin
            failures++;
            $display("FAIL reset_prefill_hazard: hit=%b stage=%0d required hit=1 stage=2",
                     bus.hazard_a, bus.hazard_a_stage);
        end
        reset     = 1'b1;
        bus.stall = 1'b1;
        tick();
        reset     = 1'b0;
        bus.stall = 1'b0;
        checks++;
        if (bus.stage_wen !== 3'b000 || bus.write_en !== 1'b0 || bus.write_reg !== 3'd0
            || bus.hazard_a !== 1'b0 || bus.hazard_a_stage !== 2'd0) begin
            failures++;
            $display("FAIL reset_midstream: wen=%b we=%b wr=%0d hz=%b hs=%0d required all 0",
                     bus.stage_wen, bus.write_en, bus.write_reg, bus.hazard_a,
                     bus.hazard_a_stage);
        end
    endtask

    task automatic test_select_latency();
        logic [1:0] sels [3];
        sels[0] = 2'd1; sels[1] = 2'd0; sels[2] = 2'd2;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            repeat (DEPTH) tick();
            bus.in_valid  = 1'b1;
            bus.write_sel = sels[k];
            bus.destReg   = 3'd5;
            bus.regB      = 3'd2;
            tick();
            set_idle();
            tick();
            checks++;
            if (bus.write_en !== 1'b0) begin
                failures++;
                $display("FAIL latency_early sel=%0d: write_en=%b required 0", sels[k],
                         bus.write_en);
            end
            tick();
            checks++;
            if (sels[k] == 2'd2) begin
                if (bus.write_en !== 1'b0) begin
                    failures++;
                    $display("FAIL select_nowrite: write_en=%b required 0", bus.write_en);
                end
            end else if (bus.write_en !== 1'b1
                         || bus.write_reg !== ((sels[k] == 2'd1) ? 3'd5 : 3'd2)) begin
                failures++;
                $display("FAIL select sel=%0d: we=%b wr=%0d required we=1 wr=%0d", sels[k],
                         bus.write_en, bus.write_reg, (sels[k] == 2'd1) ? 5 : 2);
            end
        end
    endtask

    task automatic test_zero_reg();
        set_idle();
        push(3'd4);
        bus.in_valid  = 1'b1;
        bus.write_sel = 2'd0;
        bus.regB      = 3'd0;
        tick();
        set_idle();
        checks++;
        if (bus.stage_wen[0] !== 1'b0 || bus.stage_wen[1] !== 1'b1) begin
            failures++;
            $display("FAIL zero_reg_capture: stage_wen=%b required x10", bus.stage_wen);
        end
        bus.src_a = 3'd0;
        #1;
        checks++;
        if (bus.hazard_a !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg_hazard: hazard_a=%b required 0", bus.hazard_a);
        end
    endtask

    task automatic test_stall();
        logic [DEPTH*REG_ADDR_W-1:0] exp_dest;
        set_idle();
        repeat (DEPTH) tick();
        push(3'd4);
        push(3'd6);
        exp_dest = {3'd0, 3'd4, 3'd6};
        bus.stall     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.write_sel = 2'd1;
        bus.destReg   = 3'd7;
        tick();
        tick();
        checks++;
        if (bus.stage_dest !== exp_dest || bus.stage_wen !== 3'b011) begin
            failures++;
            $display("FAIL stall_hold: dest=%h wen=%b required dest=%h wen=011",
                     bus.stage_dest, bus.stage_wen, exp_dest);
        end
        set_idle();
        tick();
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_reg !== 3'd4) begin
            failures++;
            $display("FAIL stall_release: we=%b wr=%0d required we=1 wr=4", bus.write_en,
                     bus.write_reg);
        end
    endtask

    task automatic test_flush_stall();
        logic [DEPTH*REG_ADDR_W-1:0] exp_dest;
        set_idle();
        repeat (DEPTH) tick();
        push(3'd4);
        push(3'd6);
        exp_dest = {3'd4, 3'd6, 3'd0};
        bus.stall     = 1'b1;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.write_sel = 2'd1;
        bus.destReg   = 3'd5;
        tick();
        set_idle();
        checks++;
        if (bus.stage_dest !== exp_dest || bus.stage_wen !== 3'b110) begin
            failures++;
            $display("FAIL flush_stall: dest=%h wen=%b required dest=%h wen=110",
                     bus.stage_dest, bus.stage_wen, exp_dest);
        end
    endtask

    task automatic test_youngest_hazard();
        set_idle();
        push(3'd3);
        push(3'd7);
        push(3'd3);
        bus.src_a = 3'd3;
        bus.src_b = 3'd7;
        #1;
        checks++;
        if (bus.hazard_a !== 1'b1 || bus.hazard_a_stage !== 2'd0) begin
            failures++;
            $display("FAIL youngest_a: hit=%b stage=%0d required hit=1 stage=0",
                     bus.hazard_a, bus.hazard_a_stage);
        end
        checks++;
        if (bus.hazard_b !== 1'b1 || bus.hazard_b_stage !== 2'd1) begin
            failures++;
            $display("FAIL youngest_b: hit=%b stage=%0d required hit=1 stage=1",
                     bus.hazard_b, bus.hazard_b_stage);
        end
        bus.src_b = 3'd1;
        #1;
        checks++;
        if (bus.hazard_b !== 1'b0 || bus.hazard_b_stage !== 2'd0) begin
            failures++;
            $display("FAIL nomatch_b: hit=%b stage=%0d required hit=0 stage=0",
                     bus.hazard_b, bus.hazard_b_stage);
        end
    endtask

    task automatic test_random();
        logic [DEPTH*REG_ADDR_W-1:0] exp_dest;
        logic [DEPTH-1:0]            exp_wen;
        bit                          ha, hb;
        logic [STAGE_W-1:0]          sa, sb;
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 99) < 3);
            bus.stall     = ($urandom_range(0, 99) < 25);
            bus.flush     = ($urandom_range(0, 99) < 10);
            bus.in_valid  = ($urandom_range(0, 99) < 80);
            bus.write_sel = 2'($urandom_range(0, 3));
            bus.regB      = addr_t'($urandom_range(0, 7));
            bus.destReg   = addr_t'($urandom_range(0, 7));
            bus.src_a     = addr_t'($urandom_range(0, 7));
            bus.src_b     = addr_t'($urandom_range(0, 7));
            tick();
            for (int i = 0; i < int'(DEPTH); i++) begin
                exp_dest[i*REG_ADDR_W +: REG_ADDR_W] = pipe[i].dest;
                exp_wen[i] = pipe[i].wen;
            end
            model_hazard(bus.src_a, ha, sa);
            model_hazard(bus.src_b, hb, sb);
            checks++;
            if (bus.stage_dest !== exp_dest || bus.stage_wen !== exp_wen) begin
                failures++;
                $display("FAIL rand_stages n=%0d: dest=%h wen=%b required dest=%h wen=%b", n,
                         bus.stage_dest, bus.stage_wen, exp_dest, exp_wen);
            end
            checks++;
            if (bus.write_reg !== pipe[DEPTH-1].dest || bus.write_en !== pipe[DEPTH-1].wen) begin
                failures++;
                $display("FAIL rand_final n=%0d: wr=%0d we=%b required wr=%0d we=%b", n,
                         bus.write_reg, bus.write_en, pipe[DEPTH-1].dest, pipe[DEPTH-1].wen);
            end
            checks++;
            if (bus.hazard_a !== ha || bus.hazard_a_stage !== sa
                || bus.hazard_b !== hb || bus.hazard_b_stage !== sb) begin
                failures++;
                $display("FAIL rand_hazard n=%0d: a=%b/%0d b=%b/%0d required a=%b/%0d b=%b/%0d",
                         n, bus.hazard_a, bus.hazard_a_stage, bus.hazard_b, bus.hazard_b_stage,
                         ha, sa, hb, sb);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_t b;
            b.wen  = 1'b0;
            b.dest = '0;
            pipe.push_back(b);
        end
        test_reset();
        test_select_latency();
        test_zero_reg();
        test_stall();
        test_flush_stall();
        test_youngest_hazard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
